// File: rtl/posit_extract_sched.sv
// Round-robin scheduler sharing one ES=2 posit field extractor between N_REQ
// requesters, with a single registered valid/ready output stage.

// Combinational ES=2 posit field extractor.
// Zero and NaR (inf) report scale=0 and fraction=0 alongside their flag.
module posit_extract_raw #(
  parameter int unsigned NBITS = 32,
  localparam int unsigned FRAC_W = NBITS - 5
) (
  input  logic [NBITS-1:0]  x,
  output logic              sgn,
  output logic [7:0]        scale,
  output logic [FRAC_W-1:0] frac,
  output logic              inf,
  output logic              zero,
  output logic [NBITS-2:0]  absolute
);

  localparam int unsigned CNT_W = $clog2(NBITS);

  logic [NBITS-1:0] neg_x;
  logic [NBITS-2:0] rem;
  logic [NBITS-2:0] probe;
  logic [NBITS-2:0] tmp;
  logic             r0;
  logic             found;
  logic [CNT_W-1:0] run;
  logic [7:0]       regime;
  logic [1:0]       es;
  logic             unused_bits;

  // Normalize sign, measure the regime run, then peel exponent and fraction.
  always_comb begin
    sgn      = x[NBITS-1];
    zero     = (x == '0);
    inf      = sgn && (x[NBITS-2:0] == '0);
    neg_x    = sgn ? (~x + NBITS'(1)) : x;
    absolute = neg_x[NBITS-2:0];
    rem      = neg_x[NBITS-2:0];
    r0       = rem[NBITS-2];
    probe    = r0 ? ~rem : rem;
    run      = CNT_W'(NBITS - 1);
    found    = 1'b0;
    for (int i = NBITS - 2; i >= 0; i--) begin
      if (!found && probe[i]) begin
        run   = CNT_W'(NBITS - 2 - i);
        found = 1'b1;
      end
    end
    // Shift the regime run out; the terminator bit lands at the MSB.
    tmp    = rem << run;
    es     = tmp[NBITS-3 -: 2];
    frac   = tmp[NBITS-5:1];
    regime = r0 ? (8'(run) - 8'd1) : (8'd0 - 8'(run));
    scale  = {regime[5:0], es};
    if (zero || inf) begin
      scale = '0;
      frac  = '0;
    end
  end

  assign unused_bits = ^{neg_x[NBITS-1], tmp[NBITS-2], tmp[0], regime[7:6]};

endmodule

module posit_extract_sched #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned NBITS = 32,
  localparam int unsigned TAG_W = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int unsigned POSIT_SERIALIZED_WIDTH_ES2 = NBITS + 6
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [N_REQ-1:0]                      req_valid,
  input  logic [N_REQ*NBITS-1:0]                req_data,
  output logic [N_REQ-1:0]                      req_ready,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [TAG_W-1:0]                      out_tag,
  output logic [POSIT_SERIALIZED_WIDTH_ES2-1:0] out_result,
  output logic [NBITS-2:0]                      out_absolute
);

  localparam int unsigned FRAC_W = NBITS - 5;

  logic                                  out_valid_q, out_valid_d;
  logic [TAG_W-1:0]                      out_tag_q, out_tag_d;
  logic [POSIT_SERIALIZED_WIDTH_ES2-1:0] out_result_q, out_result_d;
  logic [NBITS-2:0]                      out_absolute_q, out_absolute_d;
  logic [TAG_W-1:0]                      rr_ptr_q, rr_ptr_d;

  logic              cand_found;
  logic [TAG_W-1:0]  cand_idx;
  int unsigned       idx;
  logic              can_accept;
  logic              grant_vld;
  logic [NBITS-1:0]  operand;

  logic              x_sgn, x_inf, x_zero;
  logic [7:0]        x_scale;
  logic [FRAC_W-1:0] x_frac;
  logic [NBITS-2:0]  x_abs;

  // First valid requester at or after rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    cand_found = 1'b0;
    cand_idx   = '0;
    idx        = 0;
    for (int unsigned off = 0; off < N_REQ; off++) begin
      idx = (32'(rr_ptr_q) + off) % N_REQ;
      if (!cand_found && req_valid[TAG_W'(idx)]) begin
        cand_found = 1'b1;
        cand_idx   = TAG_W'(idx);
      end
    end
  end

  assign can_accept = !out_valid_q || out_ready;
  assign grant_vld  = cand_found && can_accept && !reset;
  assign req_ready  = grant_vld ? (N_REQ'(1) << cand_idx) : '0;
  assign operand    = req_data[32'(cand_idx)*NBITS +: NBITS];

  posit_extract_raw #(.NBITS(NBITS)) u_extract (
    .x        (operand),
    .sgn      (x_sgn),
    .scale    (x_scale),
    .frac     (x_frac),
    .inf      (x_inf),
    .zero     (x_zero),
    .absolute (x_abs)
  );

  // Output stage load/drain/stall and pointer advance.
  always_comb begin
    out_valid_d    = out_valid_q;
    out_tag_d      = out_tag_q;
    out_result_d   = out_result_q;
    out_absolute_d = out_absolute_q;
    rr_ptr_d       = rr_ptr_q;
    if (grant_vld) begin
      out_valid_d    = 1'b1;
      out_tag_d      = cand_idx;
      out_result_d   = {x_sgn, x_scale, x_frac, x_inf, x_zero};
      out_absolute_d = x_abs;
      rr_ptr_d       = (32'(cand_idx) == N_REQ - 1) ? '0 : cand_idx + TAG_W'(1);
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q    <= 1'b0;
      out_tag_q      <= '0;
      out_result_q   <= '0;
      out_absolute_q <= '0;
      rr_ptr_q       <= '0;
    end else begin
      out_valid_q    <= out_valid_d;
      out_tag_q      <= out_tag_d;
      out_result_q   <= out_result_d;
      out_absolute_q <= out_absolute_d;
      rr_ptr_q       <= rr_ptr_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_tag      = out_tag_q;
  assign out_result   = out_result_q;
  assign out_absolute = out_absolute_q;

endmodule

// File: tb/tb_posit_extract_sched.sv
// Self-checking bench for posit_extract_sched (N_REQ=4, NBITS=32).
module tb_posit_extract_sched;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned NBITS = 32;

  typedef struct packed {
    logic [1:0]  tag;
    logic [37:0] res;
    logic [30:0] ab;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [3:0]   req_valid = '0;
  logic [127:0] req_data = '0;
  logic [3:0]   req_ready;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [1:0]   out_tag;
  logic [37:0]  out_result;
  logic [30:0]  out_absolute;

  int   total = 0;
  int   bad = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  posit_extract_sched #(.N_REQ(N_REQ), .NBITS(NBITS)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_tag      (out_tag),
    .out_result   (out_result),
    .out_absolute (out_absolute)
  );

  // Bit-serial reference decode of an ES=2 posit.
  function automatic logic [37:0] model_res(input logic [31:0] x);
    logic [31:0] v;
    logic        r0;
    int          i, k, regime;
    logic [1:0]  e;
    logic [26:0] f;
    logic [7:0]  sc;
    if (x == 32'h0) return 38'h1;
    if (x == 32'h8000_0000) return {1'b1, 8'h0, 27'h0, 1'b1, 1'b0};
    v = x[31] ? -x : x;
    i = 30;
    r0 = v[30];
    k = 0;
    while (i >= 0 && v[i] == r0) begin
      k++;
      i--;
    end
    i--;
    regime = r0 ? k - 1 : -k;
    e = '0;
    for (int j = 0; j < 2; j++) begin
      e = {e[0], (i >= 0) ? v[i] : 1'b0};
      i--;
    end
    f = '0;
    for (int j = 0; j < 27; j++) begin
      f = {f[25:0], (i >= 0) ? v[i] : 1'b0};
      i--;
    end
    sc = 8'(regime * 4 + int'(e));
    return {x[31], sc, f, 1'b0, 1'b0};
  endfunction

  function automatic logic [30:0] model_abs(input logic [31:0] x);
    logic [31:0] v;
    v = x[31] ? -x : x;
    return v[30:0];
  endfunction

  function automatic logic [31:0] rand_posit();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'h0000_0001;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Scoreboard: pop on output consumption, push on request transfer.
  always @(negedge clk) begin
    exp_t e;
    logic pushed;
    if (reset) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        total++;
        if (sb_q.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected: got tag=%0d result=%h, required no output", out_tag, out_result);
        end else begin
          e = sb_q.pop_front();
          if ({out_tag, out_result, out_absolute} !== e) begin
            bad++;
            $display("FAIL sb_result: got tag=%0d result=%h abs=%h, required tag=%0d result=%h abs=%h",
                     out_tag, out_result, out_absolute, e.tag, e.res, e.ab);
          end
        end
      end
      pushed = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (!pushed && req_valid[i] && req_ready[i]) begin
          sb_q.push_back('{tag: 2'(i), res: model_res(req_data[i*32 +: 32]),
                           ab: model_abs(req_data[i*32 +: 32])});
          pushed = 1'b1;
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = '0;
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_valid = 4'hF;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) req_data[i*32 +: 32] = $urandom;
    next_cycle();
    next_cycle();
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b required 0", out_valid); end
    total++; if (out_tag !== 2'd0) begin bad++; $display("FAIL reset_tag: got %0d required 0", out_tag); end
    total++; if (out_result !== 38'h0) begin bad++; $display("FAIL reset_result: got %h required 0", out_result); end
    total++; if (out_absolute !== 31'h0) begin bad++; $display("FAIL reset_abs: got %h required 0", out_absolute); end
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready: got %b required 0000", req_ready); end
    next_cycle();
    reset = 1'b0;
    req_valid = '0;
    next_cycle();
  endtask

  task automatic test_single();
    do_reset();
    out_ready = 1'b1;
    req_data[31:0] = 32'h4000_0000;
    req_valid = 4'b0001;
    @(negedge clk);
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL single_ready: got %b required 0001", req_ready); end
    next_cycle();
    req_valid = '0;
    @(negedge clk);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_valid: got %b required 1", out_valid); end
    total++; if (out_tag !== 2'd0) begin bad++; $display("FAIL single_tag: got %0d required 0", out_tag); end
    total++; if (out_result !== 38'h0) begin bad++; $display("FAIL single_result: got %h required 0", out_result); end
    total++; if (out_absolute !== 31'h4000_0000) begin bad++; $display("FAIL single_abs: got %h required 40000000", out_absolute); end
    next_cycle();
  endtask

  task automatic test_fairness();
    int g;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) req_data[i*32 +: 32] = $urandom;
    req_valid = 4'hF;
    for (int c = 0; c < 8; c++) begin
      g = c % 4;
      @(negedge clk);
      total++;
      if (req_ready !== 4'(1 << g)) begin bad++; $display("FAIL fair_grant%0d: got %b required %b", c, req_ready, 4'(1 << g)); end
      if (c > 0) begin
        total++;
        if (out_valid !== 1'b1 || out_tag !== 2'((c - 1) % 4)) begin
          bad++; $display("FAIL fair_tag%0d: got v=%b tag=%0d required v=1 tag=%0d", c, out_valid, out_tag, (c - 1) % 4);
        end
      end
      next_cycle();
      req_data[g*32 +: 32] = rand_posit();
    end
    req_valid = '0;
    @(negedge clk);
    total++; if (out_valid !== 1'b1 || out_tag !== 2'd3) begin bad++; $display("FAIL fair_last: got v=%b tag=%0d required v=1 tag=3", out_valid, out_tag); end
    next_cycle();
  endtask

  task automatic test_backpressure();
    logic [37:0] exp_res;
    do_reset();
    for (int i = 0; i < 4; i++) req_data[i*32 +: 32] = $urandom;
    req_valid = 4'hF;
    out_ready = 1'b1;
    @(negedge clk);
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL bp_first: got %b required 0001", req_ready); end
    next_cycle();
    exp_res = model_res(req_data[31:0]);
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL bp_ready%0d: got %b required 0000", c, req_ready); end
      total++;
      if (out_valid !== 1'b1 || out_tag !== 2'd0 || out_result !== exp_res) begin
        bad++; $display("FAIL bp_hold%0d: got v=%b tag=%0d res=%h required v=1 tag=0 res=%h", c, out_valid, out_tag, out_result, exp_res);
      end
      next_cycle();
    end
    out_ready = 1'b1;
    @(negedge clk);
    total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL bp_release: got %b required 0010", req_ready); end
    next_cycle();
    req_valid = '0;
    @(negedge clk);
    total++; if (out_valid !== 1'b1 || out_tag !== 2'd1) begin bad++; $display("FAIL bp_refill: got v=%b tag=%0d required v=1 tag=1", out_valid, out_tag); end
    next_cycle();
  endtask

  task automatic test_special();
    logic [31:0] vals [4];
    logic [37:0] exps [4];
    logic [30:0] abss [4];
    vals[0] = 32'h0000_0000; exps[0] = {1'b0, 8'd0, 27'd0, 1'b0, 1'b1}; abss[0] = 31'h0;
    vals[1] = 32'h8000_0000; exps[1] = {1'b1, 8'd0, 27'd0, 1'b1, 1'b0}; abss[1] = 31'h0;
    vals[2] = 32'h4800_0000; exps[2] = {1'b0, 8'd1, 27'd0, 1'b0, 1'b0}; abss[2] = 31'h4800_0000;
    vals[3] = 32'hC000_0000; exps[3] = {1'b1, 8'd0, 27'd0, 1'b0, 1'b0}; abss[3] = 31'h4000_0000;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      req_data[95:64] = vals[k];
      req_valid = 4'b0100;
      next_cycle();
      req_valid = '0;
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || out_tag !== 2'd2 || out_result !== exps[k] || out_absolute !== abss[k]) begin
        bad++; $display("FAIL special_%h: got v=%b tag=%0d res=%h abs=%h required v=1 tag=2 res=%h abs=%h",
                        vals[k], out_valid, out_tag, out_result, out_absolute, exps[k], abss[k]);
      end
      next_cycle();
    end
  endtask

  task automatic test_wrap();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) req_data[i*32 +: 32] = $urandom;
    req_valid = 4'b1000;
    @(negedge clk);
    total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL wrap_g3: got %b required 1000", req_ready); end
    next_cycle();
    req_valid = 4'b0001;
    @(negedge clk);
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL wrap_g0: got %b required 0001", req_ready); end
    next_cycle();
    req_valid = 4'b0011;
    @(negedge clk);
    total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL wrap_ptr1: got %b required 0010", req_ready); end
    next_cycle();
    req_valid = 4'b0001;
    next_cycle();
    req_valid = '0;
    next_cycle();
  endtask

  task automatic test_reset_stall();
    do_reset();
    for (int i = 0; i < 4; i++) req_data[i*32 +: 32] = $urandom;
    out_ready = 1'b1;
    req_valid = 4'b0001;
    next_cycle();
    req_valid = '0;
    out_ready = 1'b0;
    @(negedge clk);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rst_stall_held: got %b required 1", out_valid); end
    next_cycle();
    reset = 1'b1;
    req_valid = 4'b0110;
    @(negedge clk);
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL rst_stall_ready: got %b required 0000", req_ready); end
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_stall_drop: got %b required 0", out_valid); end
    total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL rst_stall_grant: got %b required 0010", req_ready); end
    next_cycle();
    req_valid = 4'b0100;
    out_ready = 1'b1;
    @(negedge clk);
    total++; if (out_valid !== 1'b1 || out_tag !== 2'd1) begin bad++; $display("FAIL rst_stall_tag: got v=%b tag=%0d required v=1 tag=1", out_valid, out_tag); end
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL rst_stall_next: got %b required 0100", req_ready); end
    next_cycle();
    req_valid = '0;
    next_cycle();
  endtask

  task automatic test_random();
    logic [3:0] acc;
    for (int c = 0; c < 300; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 4; i++) begin
        if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
          req_data[i*32 +: 32] = rand_posit();
          req_valid[i] = 1'b1;
        end
      end
      @(negedge clk);
      acc = req_valid & req_ready;
      total++;
      if ((req_ready & ~req_valid) !== 4'b0000 || (req_ready & (req_ready - 4'd1)) !== 4'b0000) begin
        bad++; $display("FAIL rand_onehot%0d: got ready=%b valid=%b required one-hot subset", c, req_ready, req_valid);
      end
      next_cycle();
      req_valid = req_valid & ~acc;
    end
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_special();
    test_wrap();
    test_reset_stall();
    test_random();
    req_valid = '0;
    out_ready = 1'b1;
    repeat (4) next_cycle();
    @(negedge clk);
    total++;
    if (sb_q.size() != 0) begin bad++; $display("FAIL sb_drain: got %0d pending required 0", sb_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/posit_extract_sched.md
Name: posit_extract_sched

Overview:
- Round-robin scheduler that shares one combinational posit_extract_raw instance (ES=2) between N_REQ requester ports.
- Each cycle it grants at most one valid requester and feeds that requester's operand through the shared extractor.
- The serialized result, absolute value and requester tag are captured in a single registered output stage with valid/ready backpressure.
- Sits between operand-issue logic (accumulator/multiplier lanes) and downstream posit arithmetic that consumes serialized ES2 values.

Parameters:
- N_REQ, 4, number of requester ports (2..8).
- TAG_W, $clog2(N_REQ), width of the requester tag.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  N_REQ  per-requester operand valid.
- req_data  in  N_REQ*NBITS  packed operands; requester i occupies bits [i*NBITS +: NBITS].
- req_ready  out  N_REQ  per-requester accept, one-hot or zero.
- out_valid  out  1  output stage holds a result.
- out_ready  in  1  downstream accepts the result.
- out_tag  out  TAG_W  index of the requester that produced the result.
- out_result  out  POSIT_SERIALIZED_WIDTH_ES2  serialized value {sgn, scale[7:0], fraction, inf, zero}.
- out_absolute  out  NBITS-1  magnitude bits of the two's-complement-normalized operand.

Behaviour:
- Reset values (applied at the next rising edge while reset=1):
  - out_valid=0, out_tag=0, out_result=0, out_absolute=0.
  - Round-robin pointer rr_ptr=0.
- Stage acceptance: can_accept = !out_valid || out_ready.
- Arbitration (combinational):
  - Search req_valid starting at index rr_ptr, ascending with wrap-around modulo N_REQ.
  - The first set bit is the candidate.
  - grant is one-hot on the candidate only when can_accept=1; otherwise grant=0.
  - req_ready = grant.
- Handshake rules:
  - A transfer on requester i happens when req_valid[i] && req_ready[i].
  - Requesters must hold valid and data stable until accepted.
  - req_ready may depend on req_valid; req_valid must never depend on req_ready.
- Datapath:
  - The muxed operand req_data[grant_idx] drives the single shared posit_extract_raw.
  - When no grant is issued, the extractor input is don't-care.
- Latency: 1 cycle. On a transfer at edge t, out_valid=1 from edge t, with out_tag=grant_idx and the extractor outputs registered.
- Output stage update per edge:
  - transfer: load new result, out_valid=1. This covers the simultaneous drain-and-refill case when out_valid && out_ready, so throughput is 1 result/cycle.
  - no transfer, out_valid && out_ready: out_valid=0; data registers hold their values.
  - out_valid && !out_ready: all output registers hold (stall); req_ready=0.
- Pointer update:
  - On a transfer from index i, rr_ptr = (i+1) mod N_REQ.
  - With no transfer, rr_ptr holds.
  - Guarantees that any continuously valid requester is served within N_REQ transfers.
- Special values pass through unchanged from the extractor: 0x00000000 gives zero=1; 0x80000000 gives inf=1, sgn=1. The scheduler never drops or reorders accepted operands.
- Reset mid-operation:
  - A held but unconsumed result is discarded (out_valid=0).
  - rr_ptr returns to 0.
  - req_ready is forced to 0 during every cycle reset is high.
- Widths:
  - scale is 8-bit two's complement; fraction is the extractor's fraction field, unmodified.
  - out_tag is zero-extended grant_idx when N_REQ is not a power of two; indices ≥ N_REQ never appear.

Test Plan:
1. Single request: req_valid=0001, req_data[0]=0x40000000, out_ready=1 → req_ready=0001 same cycle; next cycle out_valid=1, out_tag=0, sgn=0, scale=0, fraction=0, inf=0, zero=0.
2. Round-robin fairness: all four req_valid held high for 8 cycles, out_ready=1 → grant sequence 0,1,2,3,0,1,2,3; out_tag follows one cycle later; no idle cycles.
3. Backpressure: out_valid=1, out_ready=0 for 3 cycles with req_valid=1111 → req_ready=0000, out_result/out_tag stable; on release, drain and accept occur in the same cycle; rr_ptr unchanged during the stall.
4. Special and sign values:
   - 0x00000000 → zero=1.
   - 0x80000000 → inf=1, sgn=1.
   - 0x48000000 → scale=1, sgn=0.
   - 0xC0000000 → sgn=1, scale=0, out_absolute=0x40000000 (low NBITS-1 bits).
5. Pointer wrap: req_valid=1000 then 0001 → grant 3 then 0; rr_ptr 0→0 (wrap after 3)→1.
6. Reset mid-stall: out_valid=1, out_ready=0, assert reset 1 cycle → next edge out_valid=0, rr_ptr=0; with req_valid=0110 after release, first grant=1.
